// File: rtl/multdiv_iter_counter.sv
// Step counter for the iterative multiplier/divider: counts enabled steps 0..TERMINAL.
// Latency: count/busy/done registered, update on the edge sampling en; at_tc is combinational.
// Backpressure: none; en simply stalls the count, stop aborts to IDLE holding the count.
//
// Ports:
//   clk      - rising-edge clock
//   clr_n    - asynchronous active-low reset (IDLE, count=0)
//   start    - clear count and enter RUN (loses only to stop)
//   stop     - abort to IDLE, count holds
//   en       - step enable while in RUN
//   load     - preload load_val (IDLE/RUN only); values >= TERMINAL jump to DONE
//   load_val - preload value
//   count    - current step count
//   busy     - high while in RUN
//   done     - one-cycle completion pulse
//   at_tc    - in RUN with count == TERMINAL-1 (next enabled step completes)
module multdiv_iter_counter #(
    parameter int WIDTH    = 6,
    parameter int TERMINAL = 32,
    parameter int WRAP     = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             at_tc
);

    localparam logic [WIDTH-1:0] TC    = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] TC_M1 = WIDTH'(TERMINAL - 1);

    // TERMINAL must be reachable and representable in WIDTH bits.
    generate
        if (TERMINAL < 1 || TERMINAL > (2 ** WIDTH) - 1) begin : g_bad_terminal
            $error("multdiv_iter_counter: TERMINAL out of range for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            state <= S_RUN;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (load && state != S_DONE) begin
            done <= 1'b0;
            if (load_val < TC) begin
                state <= S_RUN;
                count <= load_val;
                busy  <= 1'b1;
            end else begin
                // Preload past the end: finish silently, no done pulse.
                state <= S_DONE;
                count <= TC;
                busy  <= 1'b0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_RUN: begin
                    if (en) begin
                        if (count == TC_M1) begin
                            done <= 1'b1;
                            if (WRAP != 0) begin
                                count <= '0;
                            end else begin
                                count <= TC;
                                state <= S_DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    busy <= 1'b0;
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign at_tc = (state == S_RUN) && (count == TC_M1);

endmodule

// File: doc/multdiv_iter_counter.md
Name: multdiv_iter_counter

Overview:
- Parametrised, synchronous iteration counter for the multiplier/divider datapath.
- Replaces the fixed 6-bit ripple counter.
- Counts enabled steps from 0 to a programmable terminal count and reports busy/done.
- Supports a one-shot or free-running (wrap) mode, plus preload for early-terminating or partial operations.

Parameters:
- WIDTH, 6, counter width in bits.
- TERMINAL, 32, step count at which an operation completes; must satisfy 1 <= TERMINAL <= 2^WIDTH-1 (elaboration-time check, $error otherwise).
- WRAP, 0, 0 = one-shot (stop at TERMINAL), 1 = free-running (wrap to 0 at TERMINAL).

Ports:
- clk  input  1  rising-edge clock; only clock.
- clr_n  input  1  reset, asynchronous, active-low.
- start  input  1  synchronous: clear count and begin an operation.
- stop  input  1  synchronous abort: return to IDLE, count holds.
- en  input  1  step enable; count advances one per cycle while high in RUN.
- load  input  1  synchronous preload of load_val.
- load_val  input  WIDTH  preload value.
- count  output  WIDTH  current step count (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on completion (registered).
- at_tc  output  1  combinational: count == TERMINAL-1 and state RUN.

Behaviour:
- Reset (clr_n low, asynchronous, any time, including mid-operation):
  - state=IDLE, count=0, busy=0, done=0.
  - Release is synchronous to the next clk edge; no outputs glitch on release.
- States: IDLE, RUN, DONE. busy is registered and equals (state==RUN).
- Input priority per edge: stop > start > load > en.
- stop (any state): next state IDLE, count unchanged, done=0.
- start (any state, stop low):
  - count<=0, next state RUN, done=0.
  - Overrides load and en in the same cycle.
- load (IDLE or RUN, stop/start low):
  - load_val < TERMINAL: count<=load_val, next state RUN.
  - load_val >= TERMINAL: count<=TERMINAL, next state DONE, no done pulse.
  - load is ignored in DONE.
- RUN, en=1:
  - count < TERMINAL-1: count<=count+1.
  - count == TERMINAL-1, WRAP=0: count<=TERMINAL, next state DONE, done<=1 for exactly one cycle.
  - count == TERMINAL-1, WRAP=1: count<=0, stay RUN, done<=1 for one cycle.
- RUN, en=0: hold count and state; done<=0.
- IDLE: count holds; only start, load or reset leave IDLE.
- DONE: count holds at TERMINAL, busy=0; start re-arms; en ignored.
- Latency:
  - count updates on the edge at which en is sampled.
  - done is visible in the cycle after the final enabled step edge, i.e. coincident with count==TERMINAL (WRAP=0) or count==0 (WRAP=1).
- Operation length: from start, exactly TERMINAL enabled cycles to done, regardless of en gaps.
- Arithmetic: unsigned, WIDTH bits. count never exceeds TERMINAL, so no overflow is possible.
- done is never asserted in the same cycle as busy rising from a start.

Test Plan:
- Reset then start, en held high (WIDTH=6, TERMINAL=32, WRAP=0) -> count 0..31 on successive edges, count=32 and done=1 for one cycle 32 edges after start, busy falls with done, then count holds 32.
- Same, with en toggling 1,0 alternately -> done after 32 enabled cycles (64 clocks), count holds during en=0 cycles, busy high throughout.
- WRAP=1, TERMINAL=5, en high for 12 cycles -> count sequence 1,2,3,4,0,1,2,3,4,0,1,2, done pulses coincide with each 0, busy stays 1.
- In RUN at count=10, assert load with load_val=30 -> count=30, then 31, then 32 with done; separately load_val=40 -> count=32, state DONE, done stays 0.
- Assert clr_n low asynchronously mid-cycle at count=17 -> count=0 and busy=0 immediately without a clock edge; after release, en alone leaves count at 0 (IDLE).
- start and stop together at count=9 -> stop wins, IDLE, count=9. start and load together with load_val=20 -> count=0, RUN.
